// File: rtl/lab3_disp_pkg.sv
// Shared constants for the score display scanner: active-low segment
// patterns {g,f,e,d,c,b,a} and the scan-slot digit encoding.
package lab3_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Slot order matches the snapshot layout: units before tens, nerdians first.
    typedef enum logic [1:0] {
        DIG_N0 = 2'd0,
        DIG_N1 = 2'd1,
        DIG_H0 = 2'd2,
        DIG_H1 = 2'd3
    } digit_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational decoder from an 8-bit digit value to an active-low
// seven-segment pattern; anything outside 0-9 renders as a dash.
module bcd_to_seg7
    import lab3_disp_pkg::*;
(
    input  logic [7:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (value)
            8'd0:    seg = SEG_0;
            8'd1:    seg = SEG_1;
            8'd2:    seg = SEG_2;
            8'd3:    seg = SEG_3;
            8'd4:    seg = SEG_4;
            8'd5:    seg = SEG_5;
            8'd6:    seg = SEG_6;
            8'd7:    seg = SEG_7;
            8'd8:    seg = SEG_8;
            8'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/counter_display_scan.sv
// Time-multiplexed four-digit score display with per-frame input snapshot,
// leading-zero blanking on tens digits and a frame-counted warning dp.
module counter_display_scan
    import lab3_disp_pkg::*;
#(
    parameter int TICK_DIV    = 4,
    parameter int WARN_FRAMES = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] hipsterians1,
    input  logic [7:0] hipsterians0,
    input  logic [7:0] nerdians1,
    input  logic [7:0] nerdians0,
    input  logic       warning,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(WARN_FRAMES + 1);

    logic [PW-1:0]   presc;
    digit_e          idx;
    logic [3:0][7:0] snap;
    logic [HW-1:0]   hold;
    logic            tick;
    logic            boundary;
    logic [7:0]      sel;
    logic            blank;
    logic [6:0]      dec;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    assign boundary = tick && (idx == DIG_H1);
    assign sel      = snap[idx];
    // Slots 1 and 3 hold the tens digits; only those are blanked on zero.
    assign blank    = ((idx == DIG_N1) || (idx == DIG_H1)) && (sel == 8'd0);

    bcd_to_seg7 u_dec (
        .value(sel),
        .seg  (dec)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
            idx   <= DIG_N0;
            snap  <= '0;
            hold  <= '0;
            an    <= 4'b1111;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= digit_e'(idx + 2'd1);
            if (boundary)
                snap <= {hipsterians1, hipsterians0, nerdians1, nerdians0};
            // A fresh warning outranks the per-frame countdown.
            if (warning)
                hold <= HW'(WARN_FRAMES);
            else if (boundary && hold != '0)
                hold <= hold - 1'b1;
            an  <= ~(4'b0001 << idx);
            seg <= blank ? SEG_BLANK : dec;
            dp  <= (hold == '0);
        end
    end

endmodule

// File: tb/tb_counter_display_scan.sv
// Scoreboarded bench for counter_display_scan: a cycle model predicts
// {an,seg,dp} per edge; directed scenarios add fixed-value checks.
module tb_counter_display_scan;

    localparam int TICK_DIV    = 4;
    localparam int WARN_FRAMES = 8;

    logic       CLK;
    logic       RST;
    logic [7:0] hipsterians1, hipsterians0, nerdians1, nerdians0;
    logic       warning;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int         m_presc, m_idx, m_hold;
    logic [7:0] m_snap [4];
    logic [11:0] exp_q [$];

    counter_display_scan #(.TICK_DIV(TICK_DIV), .WARN_FRAMES(WARN_FRAMES)) dut (
        .CLK(CLK), .RST(RST),
        .hipsterians1(hipsterians1), .hipsterians0(hipsterians0),
        .nerdians1(nerdians1), .nerdians0(nerdians0),
        .warning(warning), .an(an), .seg(seg), .dp(dp)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [7:0] v;
        logic [6:0] s;
        logic [3:0] a;
        v = m_snap[m_idx];
        if ((m_idx == 1 || m_idx == 3) && v == 8'd0) s = 7'h7f;
        else if (v <= 8'd9) s = seg_tbl[v];
        else s = 7'h3f;
        a = 4'hf;
        a[m_idx] = 1'b0;
        return {a, s, (m_hold == 0)};
    endfunction

    // Reference model: predicts what the DUT drives after each rising edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_presc = 0; m_idx = 0; m_hold = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 8'd0;
            exp_q.delete();
        end else begin
            bit t, b;
            exp_q.push_back(model_out());
            t = (m_presc == TICK_DIV - 1);
            b = t && (m_idx == 3);
            m_presc = t ? 0 : m_presc + 1;
            if (t) m_idx = (m_idx + 1) % 4;
            if (b) begin
                m_snap[0] = nerdians0;    m_snap[1] = nerdians1;
                m_snap[2] = hipsterians0; m_snap[3] = hipsterians1;
            end
            if (warning) m_hold = WARN_FRAMES;
            else if (b && m_hold > 0) m_hold = m_hold - 1;
        end
    end

    always @(negedge CLK) begin
        if (RST) chk("reset_out", {an, seg, dp}, 12'hfff);
        else if (exp_q.size() > 0) chk("scan", {an, seg, dp}, exp_q.pop_front());
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] target);
        for (int k = 0; k < 64; k++) begin
            if (an == target) return;
            step();
        end
        chk("wait_an_timeout", an, target);
    endtask

    initial begin
        RST = 1; warning = 0;
        hipsterians1 = 0; hipsterians0 = 0; nerdians1 = 0; nerdians0 = 0;
        repeat (3) step();
        nerdians0 = 8'd5;
        step();
        RST = 0;
        step();
        chk("first_seg", seg, 7'h40);
        chk("first_an", an, 4'he);
        chk("first_dp", dp, 1'b1);
        repeat (16) step();
        chk("frame1_an", an, 4'he);
        chk("frame1_seg", seg, 7'h12);

        // Digit mapping and tens blanking
        hipsterians1 = 8'd2; hipsterians0 = 8'd0; nerdians1 = 8'd0; nerdians0 = 8'd1;
        repeat (32) step();
        wait_an(4'b0111); chk("map_h1", seg, 7'h24);
        wait_an(4'b1011); chk("map_h0", seg, 7'h40);
        wait_an(4'b1101); chk("map_n1_blank", seg, 7'h7f);
        wait_an(4'b1110); chk("map_n0", seg, 7'h79);

        // Input change mid-frame only lands at the next boundary
        nerdians0 = 8'd3;
        repeat (32) step();
        wait_an(4'b1110); chk("mid_old", seg, 7'h30);
        wait_an(4'b1011);
        nerdians0 = 8'd4;
        wait_an(4'b1110); chk("mid_new", seg, 7'h19);
        nerdians0 = 8'd7;
        step();
        chk("mid_hold_an", an, 4'he);
        chk("mid_hold_seg", seg, 7'h19);

        // Single warning pulse: dp held low for 8 boundaries
        warning = 1; step(); warning = 0;
        step();
        chk("warn_dp_on", dp, 1'b0);
        repeat (95) step();
        chk("warn_dp_held", dp, 1'b0);
        repeat (34) step();
        chk("warn_dp_off", dp, 1'b1);

        // Pulse on a boundary edge: reload must win over decrement
        for (int k = 0; k < 32 && !(m_presc == TICK_DIV - 1 && m_idx == 3); k++) step();
        warning = 1; step(); warning = 0;
        repeat (128) step();
        chk("bnd_dp_last", dp, 1'b0);
        step();
        chk("bnd_dp_off", dp, 1'b1);

        // Out-of-range values show a dash, tens not blanked
        nerdians0 = 8'd12; hipsterians1 = 8'd10;
        repeat (32) step();
        wait_an(4'b1110); chk("dash_n0", seg, 7'h3f);
        wait_an(4'b0111); chk("dash_h1", seg, 7'h3f);

        // Asynchronous reset mid-frame
        warning = 1; step(); warning = 0;
        wait_an(4'b1011);
        RST = 1;
        #1;
        chk("async_rst", {an, seg, dp}, 12'hfff);
        repeat (2) step();
        RST = 0;
        step();
        chk("restart", {an, seg, dp}, {4'he, 7'h40, 1'b1});
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_display_scan.md
COUNTER_DISPLAY_SCAN -- requirements
Module: counter_display_scan

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per digit slot (>=2).
REQ-002 Parameter WARN_FRAMES, default 8, number of frame boundaries the warning indicator is held (>=1).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 hipsterians1  input  8  hipsterian count tens digit, BCD in bits [3:0]; bits [7:4] normally zero.
REQ-006 hipsterians0  input  8  hipsterian count units digit, same format.
REQ-007 nerdians1  input  8  nerdian count tens digit, same format.
REQ-008 nerdians0  input  8  nerdian count units digit, same format.
REQ-009 warning  input  1  rejected-operation flag from the counter stage; may be high for one or many cycles.
REQ-010 an  output  4  digit enables, active-low, one-hot-low.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  output  1  decimal point, active-low; used as the warning indicator.

Function
REQ-013 Prescaler counts 0..TICK_DIV-1 and wraps; "tick" is the cycle in which it equals TICK_DIV-1.
REQ-014 Digit index (0..3) advances by 1 on each tick and wraps from 3 to 0; the tick taking index 3->0 is the "frame boundary".
REQ-015 At each frame boundary, all four count inputs are captured into a snapshot; between boundaries, input changes do not affect the display.
REQ-016 Index mapping: 0=nerdians0, 1=nerdians1, 2=hipsterians0, 3=hipsterians1, all taken from the snapshot.
REQ-017 an has bit[index]=0 and all other bits 1.
REQ-018 Decoding: values 0-9 use standard seven-segment patterns (0=1000000, 1=1111001, 2=0100100, 5=0010010, 8=0000000); any 8-bit value >9 shows a dash (0111111).
REQ-019 Leading-zero blanking: index 1 shows seg=1111111 when snapshot nerdians1==0; index 3 shows seg=1111111 when snapshot hipsterians1==0; units digits are never blanked.
REQ-020 Warning hold counter, width clog2(WARN_FRAMES+1): any cycle with warning=1 loads WARN_FRAMES; otherwise it decrements by 1 at each frame boundary while nonzero, saturating at 0.
REQ-021 If warning=1 coincides with a frame boundary, the reload wins and no decrement occurs.
REQ-022 dp=0 on every digit while the hold counter is nonzero, otherwise dp=1.
REQ-023 an, seg and dp are registered and reflect the index, snapshot and hold counter of the previous cycle, giving one cycle of latency.

Reset
REQ-024 While RST=1: an=1111, seg=1111111, dp=1, prescaler=0, index=0, snapshot=0, hold counter=0; this takes effect immediately, independent of CLK.
REQ-025 On the first rising edge after RST falls, index 0 is displayed with snapshot 0 (seg=1000000, an=1110).
REQ-026 Asserting RST mid-frame aborts the frame; no partial snapshot is retained.

Structure
REQ-027 Package lab3_disp_pkg holds the segment pattern constants (digits 0-9, DASH, BLANK) and the digit-index encoding.
REQ-028 One combinational sub-module, bcd_to_seg7 (8-bit value in, 7-bit active-low pattern out, dash for >9), is instantiated once on the selected snapshot digit.

Verification (TICK_DIV=4, WARN_FRAMES=8)
REQ-029 Reset scenario: apply RST, then release it with nerdians0=5. Required: outputs off during reset; first frame shows 0 on index 0; after the first frame boundary (16 cycles), index 0 shows seg=0010010.
REQ-030 Digit mapping and blanking: h1=2, h0=0, n1=0, n0=1, held for two frames. Required: an=0111 with seg=0100100; an=1011 with seg=1000000; an=1101 with seg=1111111; an=1110 with seg=1111001.
REQ-031 Input change mid-frame: change nerdians0 from 3 to 4 at index 2. Required: index 0 still shows 3 until the next frame boundary, then shows 4.
REQ-032 Warning pulse: drive warning=1 for one cycle. Required: dp=0 from the next cycle for exactly 8 frame boundaries, then dp=1; a second pulse coinciding with a boundary reloads the counter to 8.
REQ-033 Invalid value: nerdians0=8'd12 and hipsterians1=8'd10. Required: both digits show 0111111, and index 3 is not blanked.
REQ-034 Reset mid-frame: assert RST at index 2. Required: an=1111 immediately; after release, display restarts at index 0 with snapshot 0 and dp=1.
